wr_latency_pipe: RTL

- Write-latency stage directly upstream of the dual-port ECC memory; one instance per port.
- Delays each write command (enable, write-enable, address, encoded data word) by exactly WR_LATENCY clock cycles. The memory write port then commits it at the programmed latency.
- Tracks the writes still in flight and reports read-after-write hazards for the port's read address, with forwarding of the youngest pending data.
- Reports the in-flight write count and supports a synchronous flush of all pending writes.

---
 rtl/wr_latency_pipe.sv | 94 +++++++++
 1 files changed

// File: rtl/wr_latency_pipe.sv
// rtl/wr_latency_pipe.sv - write-latency shift pipe with RAW hazard detection and forwarding
// One instance per memory port; delays write commands by WR_LATENCY cycles.
module wr_latency_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int WR_LATENCY = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_en,
  input  logic                                           i_we,
  input  logic [ADDR_WIDTH-1:0]                          i_addr,
  input  logic [DATA_WIDTH+$clog2(DATA_WIDTH)+1+1:1]     i_din,
  input  logic [ADDR_WIDTH-1:0]                          i_rd_addr,
  input  logic                                           i_flush,
  output logic                                           o_en_wr,
  output logic                                           o_we,
  output logic [ADDR_WIDTH-1:0]                          o_addr_wr,
  output logic [DATA_WIDTH+$clog2(DATA_WIDTH)+1+1:1]     o_din,
  output logic [$clog2(WR_LATENCY+1)-1:0]                o_pending,
  output logic                                           o_hazard,
  output logic [DATA_WIDTH+$clog2(DATA_WIDTH)+1+1:1]     o_fwd_data
);

  localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
  localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;
  localparam int CNT_WIDTH    = $clog2(WR_LATENCY + 1);

  logic [WR_LATENCY-1:0]     st_en;
  logic [WR_LATENCY-1:0]     st_we;
  logic [WR_LATENCY-1:0]     st_valid;
  logic [ADDR_WIDTH-1:0]     st_addr [WR_LATENCY];
  logic [ENCODED_WORD+1:1]   st_din  [WR_LATENCY];

  // Stage 0 is the youngest; flush drops the presented input as well as the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_en    <= '0;
      st_we    <= '0;
      st_valid <= '0;
      for (int k = 0; k < WR_LATENCY; k++) begin
        st_addr[k] <= '0;
        st_din[k]  <= '0;
      end
    end else begin
      st_addr[0] <= i_addr;
      st_din[0]  <= i_din;
      for (int k = 1; k < WR_LATENCY; k++) begin
        st_addr[k] <= st_addr[k-1];
        st_din[k]  <= st_din[k-1];
      end
      if (i_flush) begin
        st_en    <= '0;
        st_we    <= '0;
        st_valid <= '0;
      end else begin
        st_en[0]    <= i_en;
        st_we[0]    <= i_we;
        st_valid[0] <= i_en & i_we;
        for (int k = 1; k < WR_LATENCY; k++) begin
          st_en[k]    <= st_en[k-1];
          st_we[k]    <= st_we[k-1];
          st_valid[k] <= st_valid[k-1];
        end
      end
    end
  end

  assign o_en_wr   = st_en[WR_LATENCY-1];
  assign o_we      = st_we[WR_LATENCY-1];
  assign o_addr_wr = st_addr[WR_LATENCY-1];
  assign o_din     = st_din[WR_LATENCY-1];

  always_comb begin
    o_pending = '0;
    for (int k = 0; k < WR_LATENCY; k++) begin
      o_pending = o_pending + CNT_WIDTH'(st_valid[k]);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_hazard   = 1'b0;
    o_fwd_data = '0;
    for (int k = WR_LATENCY - 1; k >= 0; k--) begin
      if (st_valid[k] && (st_addr[k] == i_rd_addr)) begin
        o_hazard   = 1'b1;
        o_fwd_data = st_din[k];
      end
    end
  end

endmodule
